calc_result_display: RTL and testbench



---
 rtl/calc_result_display.sv | 149 ++++++++++++++
 tb/tb_calc_result_display.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_display.sv
// Result display back-end: captures an arithmetic result, converts the 12-bit
// magnitude to BCD by sequential double-dabble, and scans a 4-digit 7-seg display.
module calc_result_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        load,
    input  logic [1:0]  ope,
    input  logic [15:0] acc_status,
    output logic        busy,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        led_neg,
    output logic        led_err,
    output logic [3:0]  led_rem
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    // Internal digit codes: 0-9 numeric, plus letters and blank
    localparam logic [3:0] D_R   = 4'hA;
    localparam logic [3:0] D_E   = 4'hE;
    localparam logic [3:0] D_BLK = 4'hF;

    typedef enum logic [1:0] {IDLE, START, CONV, DONE} state_t;

    state_t          state, state_nx;
    logic [11:0]     mag;
    logic            neg_q, err_q;
    logic [3:0]      rem_q;
    logic [27:0]     sreg, adj;
    logic [3:0]      iter;
    logic [3:0][3:0] dig, dig_nx;
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      idx;
    logic [15:0]     bcd;
    logic            cap_err;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = START;
            START:   state_nx = CONV;
            CONV:    if (iter == 4'd11) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state == CONV) || (state == DONE);
    assign cap_err = (ope == 2'b11) && (acc_status == 16'h0001);

    // One double-dabble step: add 3 to any BCD nibble >= 5 before the shift
    always_comb begin
        adj = sreg;
        for (int i = 0; i < 4; i++)
            if (sreg[12+4*i +: 4] >= 4'd5)
                adj[12+4*i +: 4] = sreg[12+4*i +: 4] + 4'd3;
    end

    assign bcd = sreg[27:12];

    always_comb begin
        dig_nx = bcd;
        if (BLANK_LZ && bcd[15:12] == 4'd0) begin
            dig_nx[3] = D_BLK;
            if (bcd[11:8] == 4'd0) begin
                dig_nx[2] = D_BLK;
                if (bcd[7:4] == 4'd0) dig_nx[1] = D_BLK;
            end
        end
        if (err_q) dig_nx = {D_E, D_R, D_R, D_BLK};
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            mag     <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            sreg    <= '0;
            iter    <= '0;
            dig     <= {D_BLK, D_BLK, D_BLK, 4'd0};
            led_neg <= 1'b0;
            led_err <= 1'b0;
            led_rem <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (load) begin
                    mag   <= acc_status[15:4];
                    neg_q <= (ope == 2'b01) && (acc_status[3:0] == 4'h1);
                    err_q <= cap_err;
                    rem_q <= (ope == 2'b11 && !cap_err) ? acc_status[3:0] : 4'h0;
                end
                START: begin
                    sreg <= {16'h0000, mag};
                    iter <= '0;
                end
                CONV: begin
                    sreg <= {adj[26:0], 1'b0};
                    iter <= iter + 4'd1;
                end
                DONE: begin
                    dig     <= dig_nx;
                    led_neg <= neg_q;
                    led_err <= err_q;
                    led_rem <= rem_q;
                end
                default: ;
            endcase
        end
    end

    // Digit scan keeps running regardless of conversion state
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an_n = ~(4'b0001 << idx);

    always_comb begin
        case (dig[idx])
            4'd0:    seg_n = 7'b1000000;
            4'd1:    seg_n = 7'b1111001;
            4'd2:    seg_n = 7'b0100100;
            4'd3:    seg_n = 7'b0110000;
            4'd4:    seg_n = 7'b0011001;
            4'd5:    seg_n = 7'b0010010;
            4'd6:    seg_n = 7'b0000010;
            4'd7:    seg_n = 7'b1111000;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0010000;
            D_E:     seg_n = 7'b0000110;
            D_R:     seg_n = 7'b0101111;
            default: seg_n = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display: two instances (BLANK_LZ=1 and 0)
// share stimulus; SCAN_DIV=4 keeps a full display scan at 16 clocks.
module tb_calc_result_display;
    logic        CLK = 1'b0, RSTN = 1'b0, load = 1'b0;
    logic [1:0]  ope = 2'b00;
    logic [15:0] acc_status = 16'h0000;
    logic        busy, led_neg, led_err, b_busy, b_led_neg, b_led_err;
    logic [3:0]  an_n, led_rem, b_an_n, b_led_rem;
    logic [6:0]  seg_n, b_seg_n;

    int nvec = 0;
    int nerr = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S9 = 7'b0010000,
                           SE = 7'b0000110, SR = 7'b0101111, SB = 7'b1111111;

    calc_result_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLK(CLK), .RSTN(RSTN), .load(load), .ope(ope), .acc_status(acc_status),
        .busy(busy), .an_n(an_n), .seg_n(seg_n),
        .led_neg(led_neg), .led_err(led_err), .led_rem(led_rem));

    calc_result_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .CLK(CLK), .RSTN(RSTN), .load(load), .ope(ope), .acc_status(acc_status),
        .busy(b_busy), .an_n(b_an_n), .seg_n(b_seg_n),
        .led_neg(b_led_neg), .led_err(b_led_err), .led_rem(b_led_rem));

    always #5 CLK = ~CLK;

    // Capture what each digit position shows over one full scan
    task automatic read_disp(output logic [3:0][6:0] d, output logic [3:0][6:0] bd);
        d  = 'x;
        bd = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            case (an_n)
                4'b1110: d[0] = seg_n;
                4'b1101: d[1] = seg_n;
                4'b1011: d[2] = seg_n;
                4'b0111: d[3] = seg_n;
                default: ;
            endcase
            case (b_an_n)
                4'b1110: bd[0] = b_seg_n;
                4'b1101: bd[1] = b_seg_n;
                4'b1011: bd[2] = b_seg_n;
                4'b0111: bd[3] = b_seg_n;
                default: ;
            endcase
        end
    endtask

    // Drive a one-cycle load; returns just after the capturing edge
    task automatic start_load(input logic [1:0] op, input logic [15:0] acc);
        @(negedge CLK);
        load = 1'b1; ope = op; acc_status = acc;
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        bit fin  = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge CLK);
            if (busy) seen = 1;
            else if (seen) fin = 1;
        end
        if (!fin) begin
            nvec++; nerr++;
            $display("FAIL %s timeout: busy never completed (seen high=%0d)", name, seen);
        end
    endtask

    task automatic test_reset();
        logic [3:0][6:0] d, bd;
        logic [3:0] exp_an;
        RSTN = 1'b0;
        repeat (3) @(negedge CLK);
        nvec++;
        if (busy !== 1'b0 || led_neg !== 1'b0 || led_err !== 1'b0 || led_rem !== 4'h0) begin
            nerr++;
            $display("FAIL reset_outs: busy=%b neg=%b err=%b rem=%h want 0 0 0 0", busy, led_neg, led_err, led_rem);
        end
        nvec++;
        if (an_n !== 4'b1110 || seg_n !== S0) begin
            nerr++;
            $display("FAIL reset_scan: an_n=%b seg_n=%b want 1110 %b", an_n, seg_n, S0);
        end
        RSTN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            nvec++;
            if (an_n !== exp_an) begin
                nerr++;
                $display("FAIL scan_seq[%0d]: an_n=%b want %b", k, an_n, exp_an);
            end
        end
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, SB, SB, S0}) begin
            nerr++;
            $display("FAIL reset_disp: got %h want %h", d, {SB, SB, SB, S0});
        end
    endtask

    task automatic test_add();
        logic [3:0][6:0] d, bd;
        int hi = 0;
        int first = -1;
        @(negedge CLK);
        load = 1'b1; ope = 2'b00; acc_status = 16'h4D20;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            load = 1'b0;
            if (busy === 1'b1) begin
                hi++;
                if (first < 0) first = k;
            end
        end
        nvec++;
        if (hi != 13 || first != 1) begin
            nerr++;
            $display("FAIL add_busy: high=%0d first=%0d want 13 1", hi, first);
        end
        read_disp(d, bd);
        nvec++;
        if (d !== {S1, S2, S3, S4} || led_neg !== 1'b0 || led_err !== 1'b0 || led_rem !== 4'h0) begin
            nerr++;
            $display("FAIL add_1234: disp=%h leds=%b%b%h want %h 000", d, led_neg, led_err, led_rem, {S1, S2, S3, S4});
        end
    endtask

    task automatic test_sub();
        logic [3:0][6:0] d, bd;
        start_load(2'b01, 16'h0071);
        wait_done("sub_neg");
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, SB, SB, S7} || led_neg !== 1'b1 || led_err !== 1'b0 || led_rem !== 4'h0) begin
            nerr++;
            $display("FAIL sub_neg: disp=%h neg=%b err=%b rem=%h want %h 1 0 0", d, led_neg, led_err, led_rem, {SB, SB, SB, S7});
        end
        start_load(2'b01, 16'h0070);
        wait_done("sub_pos");
        nvec++;
        if (led_neg !== 1'b0) begin
            nerr++;
            $display("FAIL sub_pos: led_neg=%b want 0", led_neg);
        end
    endtask

    task automatic test_div();
        logic [3:0][6:0] d, bd;
        start_load(2'b11, 16'h0033);
        wait_done("div_rem");
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, SB, SB, S3} || led_rem !== 4'h3 || led_err !== 1'b0 || led_neg !== 1'b0) begin
            nerr++;
            $display("FAIL div_rem: disp=%h rem=%h err=%b neg=%b want %h 3 0 0", d, led_rem, led_err, led_neg, {SB, SB, SB, S3});
        end
        start_load(2'b11, 16'h0001);
        wait_done("div_err");
        read_disp(d, bd);
        nvec++;
        if (d !== {SE, SR, SR, SB} || led_err !== 1'b1 || led_rem !== 4'h0 || led_neg !== 1'b0) begin
            nerr++;
            $display("FAIL div_err: disp=%h err=%b rem=%h neg=%b want %h 1 0 0", d, led_err, led_rem, led_neg, {SE, SR, SR, SB});
        end
    endtask

    task automatic test_max_blank();
        logic [3:0][6:0] d, bd;
        start_load(2'b10, 16'hFFF0);
        wait_done("max");
        read_disp(d, bd);
        nvec++;
        if (d !== {S4, S0, S9, S5} || led_err !== 1'b0 || led_rem !== 4'h0 || led_neg !== 1'b0) begin
            nerr++;
            $display("FAIL max_4095: disp=%h err=%b rem=%h neg=%b want %h 0 0 0", d, led_err, led_rem, led_neg, {S4, S0, S9, S5});
        end
        start_load(2'b00, 16'h0050);
        wait_done("mag5");
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, SB, SB, S5}) begin
            nerr++;
            $display("FAIL blank_lz1: got %h want %h", d, {SB, SB, SB, S5});
        end
        nvec++;
        if (bd !== {S0, S0, S0, S5}) begin
            nerr++;
            $display("FAIL blank_lz0: got %h want %h", bd, {S0, S0, S0, S5});
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0][6:0] d, bd;
        int late = 0;
        start_load(2'b00, 16'h0640);
        repeat (4) @(negedge CLK);
        load = 1'b1; acc_status = 16'h0C80;
        @(negedge CLK);
        load = 1'b0;
        wait_done("busy_ignore");
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (busy !== 1'b0) late++;
        end
        nvec++;
        if (late != 0) begin
            nerr++;
            $display("FAIL busy_noqueue: busy high %0d cycles after done, want 0", late);
        end
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, S1, S0, S0}) begin
            nerr++;
            $display("FAIL busy_ignore: got %h want %h", d, {SB, S1, S0, S0});
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [3:0][6:0] d, bd;
        int late = 0;
        start_load(2'b11, 16'h0033);
        wait_done("pre_rem");
        nvec++;
        if (led_rem !== 4'h3) begin
            nerr++;
            $display("FAIL pre_rem: led_rem=%h want 3", led_rem);
        end
        start_load(2'b00, 16'h4D20);
        repeat (6) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || led_rem !== 4'h0 || led_neg !== 1'b0 || led_err !== 1'b0 || an_n !== 4'b1110) begin
            nerr++;
            $display("FAIL mid_reset: busy=%b rem=%h neg=%b err=%b an_n=%b want 0 0 0 0 1110", busy, led_rem, led_neg, led_err, an_n);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (busy !== 1'b0) late++;
        end
        nvec++;
        if (late != 0) begin
            nerr++;
            $display("FAIL mid_reset_busy: busy high %0d cycles after reset, want 0", late);
        end
        read_disp(d, bd);
        nvec++;
        if (d !== {SB, SB, SB, S0}) begin
            nerr++;
            $display("FAIL mid_reset_disp: got %h want %h", d, {SB, SB, SB, S0});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_div();
        test_max_blank();
        test_busy_ignore();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
